// File: rtl/opseq_pkg.sv
// Shared types and constants for the operation sequencer.
package opseq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MULT  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_LOAD  = 3'd3,
    ST_STORE = 3'd4,
    ST_GAP   = 3'd5
  } state_e;

  localparam int unsigned OP_W = 32;

  localparam logic [3:0] OP_IDLE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_STORE = 4'd3;

endpackage

// File: rtl/opseq_fifo.sv
// Command queue: first-word-fall-through FIFO; push while full is taken only
// when a pop happens in the same cycle.
module opseq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 41
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: pointers define validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/op_sequencer.sv
// Command sequencer in front of the compute controller: queues commands and
// steps multiply / serial-load / serial-store ops. OPSEQ_PERF_EN adds a busy-cycle counter.
module op_sequencer
  import opseq_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned MM_CYCLES    = 80,
  parameter int unsigned DRAIN_CYCLES = 16,
  parameter int unsigned CNT_W        = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_op,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [31:0]      wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [31:0]      rd_data,
  output logic [31:0]      ctrl_op,
  output logic             ctrl_en,
  output logic [31:0]      ctrl_in,
  input  logic [31:0]      ctrl_out,
`ifdef OPSEQ_PERF_EN
  output logic [31:0]      perf_busy_cycles,
`endif
  output logic             busy
);

  localparam int unsigned QW = CNT_W + OP_W;
  localparam logic [CNT_W-1:0] MM_LAST    = CNT_W'(MM_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  state_e           state_q, state_d;
  logic [31:0]      op_q, op_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] iss_q, iss_d;
  logic             rd_valid_q, rd_valid_d;
  logic [31:0]      rd_data_q, rd_data_d;

  logic             pop_c;
  logic             dispatch_c;
  logic             issue_c;
  logic             fifo_full;
  logic             fifo_empty;
  logic [QW-1:0]    fifo_dout;
  logic [31:0]      head_op;
  logic [CNT_W-1:0] head_len;

  opseq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (QW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_valid),
    .din   ({cmd_len, cmd_op}),
    .pop   (pop_c),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_op   = fifo_dout[OP_W-1:0];
  assign head_len  = fifo_dout[QW-1:OP_W];
  // A full queue still accepts when the head is popped this cycle.
  assign cmd_ready = !fifo_full || pop_c;
  assign busy      = !fifo_empty || (state_q != ST_IDLE);
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    iss_d      = iss_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;
    pop_c      = 1'b0;
    dispatch_c = 1'b0;
    issue_c    = 1'b0;
    ctrl_op    = OP_W'(OP_IDLE);
    ctrl_en    = 1'b0;
    ctrl_in    = '0;
    wr_ready   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        dispatch_c = !fifo_empty;
      end
      ST_MULT: begin
        ctrl_op = op_q;
        ctrl_en = 1'b1;
        if (cnt_q == MM_LAST) begin
          cnt_d   = '0;
          state_d = (DRAIN_CYCLES == 0) ? ST_GAP : ST_DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        ctrl_en = 1'b1;
        if (cnt_q == DRAIN_LAST) begin
          cnt_d   = '0;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_LOAD: begin
        ctrl_op  = op_q;
        wr_ready = 1'b1;
        ctrl_en  = wr_valid;
        ctrl_in  = wr_data;
        if (wr_valid) begin
          if (cnt_q == len_q - CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = ST_GAP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_STORE: begin
        // iss_q counts beats read from the controller, cnt_q beats delivered.
        ctrl_op = op_q;
        issue_c = (!rd_valid_q || rd_ready) && (iss_q != len_q);
        ctrl_en = issue_c;
        if (issue_c) begin
          iss_d      = iss_q + CNT_W'(1);
          rd_data_d  = ctrl_out;
          rd_valid_d = 1'b1;
        end else if (rd_valid_q && rd_ready) begin
          rd_valid_d = 1'b0;
        end
        if (rd_valid_q && rd_ready) begin
          if (cnt_q == len_q - CNT_W'(1)) begin
            cnt_d   = '0;
            iss_d   = '0;
            state_d = ST_GAP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_GAP: begin
        ctrl_en    = 1'b1;
        state_d    = ST_IDLE;
        dispatch_c = !fifo_empty;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Pop the head and route by opcode; zero-length transfers skip straight to GAP.
    if (dispatch_c) begin
      pop_c = 1'b1;
      op_d  = head_op;
      len_d = head_len;
      cnt_d = '0;
      iss_d = '0;
      case (head_op[3:0])
        OP_MULT:  state_d = ST_MULT;
        OP_LOAD:  state_d = (head_len == '0) ? ST_GAP : ST_LOAD;
        OP_STORE: state_d = (head_len == '0) ? ST_GAP : ST_STORE;
        default:  state_d = ST_GAP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      iss_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      iss_q      <= iss_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

`ifdef OPSEQ_PERF_EN
  logic [31:0] perf_q, perf_d;

  // Saturating count of busy cycles.
  always_comb begin
    perf_d = perf_q;
    if (busy && (perf_q != '1)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_busy_cycles = perf_q;
`endif

endmodule

// File: tb/tb_op_sequencer.sv
// Scoreboard bench for op_sequencer: directed timing cases plus a random command mix.
module tb_op_sequencer;
  import opseq_pkg::*;

  localparam int unsigned CNT_W = 9;
  localparam int unsigned MM    = 80;
  localparam int unsigned DR    = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [31:0]      cmd_op;
  logic [CNT_W-1:0] cmd_len;
  logic             wr_valid;
  logic             wr_ready;
  logic [31:0]      wr_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [31:0]      rd_data;
  logic [31:0]      ctrl_op;
  logic             ctrl_en;
  logic [31:0]      ctrl_in;
  logic [31:0]      ctrl_out;
  logic             busy;
`ifdef OPSEQ_PERF_EN
  logic [31:0]      perf_busy_cycles;
`endif

  op_sequencer #(
    .FIFO_DEPTH   (4),
    .MM_CYCLES    (MM),
    .DRAIN_CYCLES (DR),
    .CNT_W        (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .ctrl_op   (ctrl_op),
    .ctrl_en   (ctrl_en),
    .ctrl_in   (ctrl_in),
    .ctrl_out  (ctrl_out),
`ifdef OPSEQ_PERF_EN
    .perf_busy_cycles (perf_busy_cycles),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=0x%08h expected=nothing t=%0t", name, act, $time);
  endtask

  // Data sources: the k-th load beat carries wr_list[k], the k-th store beat rd_list[k].
  logic [31:0] wr_list [512];
  logic [31:0] rd_list [512];
  logic [8:0]  wr_src_ptr = '0;
  logic [8:0]  rd_src_ptr = '0;
  logic [8:0]  ld_exp_ptr = '0;
  logic [8:0]  st_exp_ptr = '0;

  logic [31:0] exp_seg [$];
  logic [31:0] exp_ld  [$];
  logic [31:0] exp_rd  [$];

  // Reference model: what an accepted command must produce, in order.
  task automatic model_accept(input logic [31:0] op, input logic [CNT_W-1:0] len);
    case (op[3:0])
      OP_MULT: exp_seg.push_back(op);
      OP_LOAD: if (len != '0) begin
        exp_seg.push_back(op);
        for (int k = 0; k < int'(len); k++) begin
          exp_ld.push_back(wr_list[ld_exp_ptr]);
          ld_exp_ptr = ld_exp_ptr + 9'd1;
        end
      end
      OP_STORE: if (len != '0) begin
        exp_seg.push_back(op);
        for (int k = 0; k < int'(len); k++) begin
          exp_rd.push_back(rd_list[st_exp_ptr]);
          st_exp_ptr = st_exp_ptr + 9'd1;
        end
      end
      default: ;
    endcase
  endtask

  // Driver for data-side inputs: 0 random, 1 alternating wr_valid, 2 rd_ready held by rd_block.
  int drv_mode = 0;
  bit rd_block = 1'b0;

  initial begin
    bit hs_wr;
    bit hs_st;
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    wr_data  = '0;
    ctrl_out = '0;
    forever begin
      @(negedge clk);
      hs_wr = wr_valid && wr_ready;
      hs_st = ctrl_en && (ctrl_op[3:0] == OP_STORE);
      @(posedge clk);
      #1;
      if (hs_wr) wr_src_ptr = wr_src_ptr + 9'd1;
      if (hs_st) rd_src_ptr = rd_src_ptr + 9'd1;
      wr_data  = wr_list[wr_src_ptr];
      ctrl_out = rd_list[rd_src_ptr];
      case (drv_mode)
        1: begin wr_valid = !wr_valid; rd_ready = 1'b1; end
        2: begin wr_valid = 1'b0; rd_ready = !rd_block; end
        default: begin
          wr_valid = ($urandom_range(0, 1) == 1);
          rd_ready = ($urandom_range(0, 3) != 0);
        end
      endcase
    end
  end

  // Monitor: op segments, post-segment enable windows, load and read beats.
  bit          mon_en    = 1'b0;
  bit          in_seg    = 1'b0;
  logic [31:0] seg_op    = '0;
  int          seg_len   = 0;
  int          post_left = 0;
  bit          hold_prev = 1'b0;
  logic [31:0] hold_data = '0;
  int          ld_beats  = 0;
  int          rd_beats  = 0;

  always @(negedge clk) begin
    logic [31:0] e;
    if (mon_en) begin
      if (post_left > 0) begin
        check("post_ctrl_en", 32'(ctrl_en), 32'd1);
        check("post_ctrl_op", ctrl_op, 32'd0);
        post_left--;
      end
      if (ctrl_op != 32'd0) begin
        if (!in_seg) begin
          in_seg  = 1'b1;
          seg_op  = ctrl_op;
          seg_len = 0;
        end else begin
          check("seg_op_stable", ctrl_op, seg_op);
        end
        seg_len++;
      end else if (in_seg) begin
        in_seg = 1'b0;
        if (exp_seg.size() == 0) begin
          unexpected("seg_unexpected", seg_op);
        end else begin
          e = exp_seg.pop_front();
          check("seg_op", seg_op, e);
          check("seg_end_ctrl_en", 32'(ctrl_en), 32'd1);
          if (e[3:0] == OP_MULT) begin
            check("mult_cycles", 32'(seg_len), 32'(MM));
            post_left = DR;
          end
        end
      end
      if (ctrl_en && (ctrl_op[3:0] == OP_LOAD)) begin
        ld_beats++;
        check("ld_wr_ready", 32'(wr_ready), 32'd1);
        if (exp_ld.size() == 0) unexpected("ld_unexpected", ctrl_in);
        else check("ld_ctrl_in", ctrl_in, exp_ld.pop_front());
      end
      if (hold_prev) begin
        check("rd_hold_valid", 32'(rd_valid), 32'd1);
        check("rd_hold_data", rd_data, hold_data);
      end
      if (rd_valid && rd_ready) begin
        rd_beats++;
        if (exp_rd.size() == 0) unexpected("rd_unexpected", rd_data);
        else check("rd_data", rd_data, exp_rd.pop_front());
      end
      hold_prev = rd_valid && !rd_ready;
      hold_data = rd_data;
    end
  end

  // Offer one command at posedge+1 until accepted (bounded); ends at posedge+1.
  task automatic push(input logic [31:0] op, input logic [CNT_W-1:0] len);
    bit ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    if (ok) model_accept(op, len);
    else check("push_timeout", 32'(cmd_ready), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ctrl_op"},   ctrl_op, 32'd0);
    check({tag, "_ctrl_en"},   32'(ctrl_en), 32'd0);
    check({tag, "_ctrl_in"},   ctrl_in, 32'd0);
    check({tag, "_rd_valid"},  32'(rd_valid), 32'd0);
    check({tag, "_rd_data"},   rd_data, 32'd0);
    check({tag, "_wr_ready"},  32'(wr_ready), 32'd0);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_busy"},      32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    int base;
    int r;
    logic [31:0]      op;
    logic [CNT_W-1:0] len;
    bit ok;

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_len   = '0;
    for (int i = 0; i < 512; i++) begin
      wr_list[i] = $urandom;
      rd_list[i] = $urandom;
    end
    wr_list[0] = 32'hA;
    wr_list[1] = 32'hB;
    wr_list[2] = 32'hC;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    align();
    reset  = 1'b0;
    mon_en = 1'b1;

    // Multiply: busy must fall 98 cycles after the pop cycle.
    push(32'h0000_8211, '0);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    check("mult_busy_fall", 32'(n), 32'd98);

    // Load with alternating wr_valid: three beats A, B, C.
    drv_mode = 1;
    align();
    base = ld_beats;
    push(32'h0000_0012, CNT_W'(3));
    wait_idle(200);
    check("load_beats", 32'(ld_beats - base), 32'd3);

    // Store held off by rd_ready low.
    drv_mode = 2;
    rd_block = 1'b1;
    align();
    base = rd_beats;
    push(32'h0000_0043, CNT_W'(2));
    repeat (5) @(negedge clk);
    check("store_bp_valid", 32'(rd_valid), 32'd1);
    check("store_bp_beats", 32'(rd_beats - base), 32'd0);
    rd_block = 1'b0;
    wait_idle(200);
    check("store_beats", 32'(rd_beats - base), 32'd2);

    // Zero-length store: one GAP cycle, no read beats.
    drv_mode = 0;
    align();
    push(32'h0000_0013, '0);
    @(negedge clk);
    check("len0_busy_pop", 32'(busy), 32'd1);
    check("len0_en_pop", 32'(ctrl_en), 32'd0);
    check("len0_rd_valid0", 32'(rd_valid), 32'd0);
    @(negedge clk);
    check("len0_gap_en", 32'(ctrl_en), 32'd1);
    check("len0_gap_busy", 32'(busy), 32'd1);
    check("len0_rd_valid1", 32'(rd_valid), 32'd0);
    @(negedge clk);
    check("len0_idle_busy", 32'(busy), 32'd0);
    align();

    // Queue full behind a long multiply.
    push(32'h0000_0031, '0);
    for (int i = 0; i < 4; i++) push(32'h0000_00A3 + 32'(i << 4), CNT_W'(1));
    cmd_valid = 1'b1;
    cmd_op    = 32'h0000_0E03;
    cmd_len   = CNT_W'(1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_cmd_ready", 32'(cmd_ready), 32'd0);
      align();
    end
    cmd_valid = 1'b0;
    align();
    cmd_valid = 1'b1;
    cmd_op    = 32'h0000_0F03;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = cmd_ready;
      align();
    end
    cmd_valid = 1'b0;
    check("full_swap_accepted", 32'(ok), 32'd1);
    if (ok) model_accept(32'h0000_0F03, CNT_W'(1));
    @(negedge clk);
    check("full_after_swap", 32'(cmd_ready), 32'd0);
    wait_idle(1000);

    // Random command mix.
    align();
    for (int c = 0; c < 40; c++) begin
      r   = int'($urandom_range(0, 9));
      len = CNT_W'($urandom_range(0, 4));
      op  = {$urandom, 4'h0} & 32'h00FF_FFF0;
      if (r == 0)      op[3:0] = OP_MULT;
      else if (r < 5)  op[3:0] = OP_LOAD;
      else if (r < 9)  op[3:0] = OP_STORE;
      else             op[3:0] = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(4, 15));
      push(op, len);
    end
    wait_idle(20000);
    repeat (2) @(negedge clk);
    check("end_seg_queue", 32'(exp_seg.size()), 32'd0);
    check("end_ld_queue", 32'(exp_ld.size()), 32'd0);
    check("end_rd_queue", 32'(exp_rd.size()), 32'd0);

    // Reset 40 cycles into a multiply with two commands queued.
    align();
    push(32'h0000_5551, '0);
    push(32'h0000_0023, CNT_W'(2));
    push(32'h0000_0032, CNT_W'(2));
    n = 0;
    for (int i = 0; i < 200 && n < 40; i++) begin
      @(negedge clk);
      if (ctrl_op == 32'h0000_5551) n++;
    end
    check("rst_mult_reached", 32'(n), 32'd40);
    mon_en = 1'b0;
    align();
    reset = 1'b1;
    align();
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("midrst");
    exp_seg.delete();
    exp_ld.delete();
    exp_rd.delete();
    n = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (busy || ctrl_en || rd_valid || wr_ready) n++;
    end
    check("midrst_quiet", 32'(n), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/op_sequencer.md
OP_SEQUENCER -- requirements
Module: op_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command queue depth (power of 2, >=2).
REQ-002 SHALL have parameter MM_CYCLES, default 80, cycles the operation word is held for a multiply.
REQ-003 SHALL have parameter DRAIN_CYCLES, default 16, idle cycles after a multiply before the next command.
REQ-004 SHALL have parameter CNT_W, default 9, beat/cycle counter width.
REQ-005 SHALL use clock clk; reset is reset, synchronous, active-high.
REQ-006 SHALL have ports:
  - cmd_valid, in, 1: command offered.
  - cmd_ready, out, 1: queue not full.
  - cmd_op, in, 32: operation word; [3:0] opcode.
  - cmd_len, in, CNT_W: beat count for opcodes 2/3.
  - wr_valid / wr_ready, in / out, 1: serial-write beat handshake.
  - wr_data, in, 32: write beat.
  - rd_valid / rd_ready, out / in, 1: serial-read beat handshake.
  - rd_data, out, 32: read beat.
  - ctrl_op, out, 32: operation word to the compute controller.
  - ctrl_en, out, 1: controller enable.
  - ctrl_in, out, 32: controller input data.
  - ctrl_out, in, 32: controller output data.
  - busy, out, 1: queue non-empty or state not IDLE.

Function
REQ-007 Handshake rules:
  - Command accepted when cmd_valid && cmd_ready.
  - Command popped only in IDLE or GAP-exit.
  - Accept and pop in the same cycle are legal when full.
REQ-008 States SHALL be IDLE, MULT, DRAIN, LOAD, STORE, GAP.
REQ-009 IDLE with queue non-empty: pop, then go to MULT (opcode 1), LOAD (2) or STORE (3); any other opcode goes to GAP.
REQ-010 MULT: ctrl_op = cmd_op and ctrl_en = 1 for exactly MM_CYCLES cycles, then DRAIN.
REQ-011 DRAIN: ctrl_op = 0 and ctrl_en = 1 for DRAIN_CYCLES cycles, then GAP.
REQ-012 LOAD:
  - ctrl_op = cmd_op; ctrl_en = wr_valid; wr_ready = 1; ctrl_in = wr_data.
  - Each handshake counts one beat.
  - After cmd_len beats, go to GAP.
REQ-013 STORE:
  - ctrl_op = cmd_op; rd_data = ctrl_out registered one cycle; rd_valid asserted one cycle after each issued beat.
  - ctrl_en = 1 only when no beat is pending or rd_ready.
  - Go to GAP after cmd_len beats are delivered.
REQ-014 GAP: ctrl_op = 0 for exactly one cycle, so every command presents a fresh opcode edge; then IDLE.
REQ-015 cmd_len = 0 in LOAD/STORE SHALL transfer no beats and go straight to GAP.
REQ-016 Outside MULT, LOAD and STORE, ctrl_op[3:0] SHALL be 0.
REQ-017 Outside LOAD and STORE, ctrl_en SHALL be 1 except in IDLE, where it is 0.
REQ-018 Counters SHALL be CNT_W bits and never wrap; MM_CYCLES and DRAIN_CYCLES < 2**CNT_W.

Reset
REQ-019 On reset, outputs SHALL be:
  - ctrl_op = 0, ctrl_en = 0, ctrl_in = 0, rd_valid = 0, rd_data = 0;
  - wr_ready = 0, cmd_ready = 1, busy = 0;
  - queue empty, state IDLE, counters 0.
REQ-020 Reset mid-operation SHALL abort the current command and discard queued commands, with no further beats.

Configuration
REQ-021 With OPSEQ_PERF_EN defined: output perf_busy_cycles (32-bit) counts cycles with busy = 1, saturates at all-ones, and clears on reset.
REQ-022 Without OPSEQ_PERF_EN: perf_busy_cycles port and its counter SHALL be absent.

Structure
REQ-023 Package opseq_pkg SHALL hold the state enum and opcode constants OP_IDLE=0, OP_MULT=1, OP_LOAD=2, OP_STORE=3.
REQ-024 The command queue SHALL be sub-module opseq_fifo: FIFO storing {cmd_len, cmd_op}, with full/empty flags.

Verification
REQ-025 Multiply timing: push op 0x00008211 (opcode 1)
  - ctrl_op = 0x00008211 for 80 cycles.
  - Then 16 cycles with opcode 0, then 1 GAP cycle.
  - busy falls 98 cycles after the pop.
REQ-026 Load with stalls: push opcode 2 (op 0x12), len 3; drive wr_valid alternating with values 0xA, 0xB, 0xC
  - ctrl_en pulses exactly 3 times with ctrl_in = 0xA, 0xB, 0xC.
  - Then GAP.
REQ-027 Store backpressure: push opcode 3, len 2, rd_ready low for 5 cycles
  - rd_valid holds with rd_data stable.
  - Exactly 2 beats are delivered after rd_ready rises.
REQ-028 Queue full: push 4 commands while busy
  - cmd_ready = 0; a 5th push is ignored.
  - Simultaneous pop/push keeps count at 4.
REQ-029 Reset during MULT at cycle 40 with 2 commands queued: the next cycle shows all REQ-019 values and no queued command executes.
REQ-030 cmd_len = 0 store: no rd_valid; a single GAP cycle follows, then IDLE.
